// File: rtl/baby_store.sv
`timescale 1ns/1ps
// Main store for the Manchester Baby core: 32 x 32-bit words plus a byte-serial program loader.
// Latency: core reads are combinational; core and loader writes land on the rising edge.
// Backpressure: load_ready is high only in LOAD; while it is low the host must hold its byte.
module baby_store (
    input  logic        clock,
    input  logic        reset_i,
    input  logic [4:0]  ram_addr_i,
    input  logic        ram_rw_en_i,
    input  logic [31:0] ram_data_i,
    output logic [31:0] ram_data_o,
    input  logic        load_mode_i,
    input  logic        load_valid_i,
    input  logic [7:0]  load_byte_i,
    output logic        load_ready_o,
    output logic        load_done_o,
    output logic [7:0]  load_sum_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] store [32];
    logic [1:0]  byte_cnt;
    logic [4:0]  word_addr;
    // Holds bytes 0..2 of the word being assembled; byte 3 goes straight
    // into the store together with these on the completing edge.
    logic [23:0] asm_reg;
    logic [7:0]  sum;
    logic        ready_q;
    logic        done_q;

    logic accept;
    logic word_fin;
    logic start;

    // A byte is only taken while the host still owns the write path, so a
    // byte offered in the same cycle load_mode drops is part of the discarded partial word.
    assign accept   = (state == LOAD) && load_mode_i && load_valid_i;
    assign word_fin = accept && (byte_cnt == 2'd3);
    assign start    = (state == IDLE) && load_mode_i;

    assign ram_data_o   = store[ram_addr_i];
    assign load_ready_o = ready_q;
    assign load_done_o  = done_q;
    assign load_sum_o   = sum;

    // Next-state logic for the loader.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (load_mode_i) next_state = LOAD;
            LOAD: begin
                if (!load_mode_i)
                    next_state = IDLE;
                else if (word_fin && (word_addr == 5'd31))
                    next_state = DONE;
            end
            DONE: if (!load_mode_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register; ready/done are registered copies of the next state decode.
    always_ff @(posedge clock) begin
        if (reset_i) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == LOAD);
            done_q  <= (next_state == DONE);
        end
    end

    // Loader datapath: byte assembly, counters and running checksum.
    always_ff @(posedge clock) begin
        if (reset_i || start) begin
            byte_cnt  <= 2'd0;
            word_addr <= 5'd0;
            asm_reg   <= 24'd0;
            sum       <= 8'd0;
        end else if (accept) begin
            case (byte_cnt)
                2'd0:    asm_reg[7:0]   <= load_byte_i;
                2'd1:    asm_reg[15:8]  <= load_byte_i;
                2'd2:    asm_reg[23:16] <= load_byte_i;
                default: asm_reg        <= asm_reg;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
            sum      <= sum + load_byte_i;
            if (word_fin)
                word_addr <= word_addr + 5'd1;
        end
    end

    // Storage array; loader and core writes are exclusive because the
    // loader only writes while load_mode is high, which blocks the core.
    always_ff @(posedge clock) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++)
                store[i] <= 32'd0;
        end else if (word_fin) begin
            store[word_addr] <= {load_byte_i, asm_reg};
        end else if (ram_rw_en_i && !load_mode_i) begin
            store[ram_addr_i] <= ram_data_i;
        end
    end

endmodule

// File: tb/tb_baby_store.sv
`timescale 1ns/1ps
// Directed bench for baby_store: reset, core read/write, full and stalled
// program loads, abort and reset during a load.
module tb_baby_store;

    logic        clock;
    logic        reset_i;
    logic [4:0]  ram_addr_i;
    logic        ram_rw_en_i;
    logic [31:0] ram_data_i;
    logic [31:0] ram_data_o;
    logic        load_mode_i;
    logic        load_valid_i;
    logic [7:0]  load_byte_i;
    logic        load_ready_o;
    logic        load_done_o;
    logic [7:0]  load_sum_o;

    int n_checks = 0;
    int n_fail   = 0;

    baby_store dut (
        .clock        (clock),
        .reset_i      (reset_i),
        .ram_addr_i   (ram_addr_i),
        .ram_rw_en_i  (ram_rw_en_i),
        .ram_data_i   (ram_data_i),
        .ram_data_o   (ram_data_o),
        .load_mode_i  (load_mode_i),
        .load_valid_i (load_valid_i),
        .load_byte_i  (load_byte_i),
        .load_ready_o (load_ready_o),
        .load_done_o  (load_done_o),
        .load_sum_o   (load_sum_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one byte and hold it until the loader takes it (bounded wait).
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard        = 0;
        load_valid_i = 1'b1;
        load_byte_i  = b;
        while (!load_ready_o && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_byte_timeout: ready=%0b required 1", load_ready_o);
        end
        tick();
        load_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        ram_rw_en_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ram_addr_i = 5'($urandom_range(0, 31));
            ram_data_i = $urandom;
            tick();
        end
        ram_rw_en_i = 1'b0;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ram_addr_i = 5'(a);
            #1;
            n_checks++;
            if (ram_data_o !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_word[%0d]: got %h required 00000000", a, ram_data_o);
            end
        end
        n_checks++;
        if ({load_ready_o, load_done_o, load_sum_o} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%0b done=%0b sum=%h required 0 0 00",
                     load_ready_o, load_done_o, load_sum_o);
        end
    endtask

    task automatic test_core_rw();
        ram_rw_en_i = 1'b1;
        ram_addr_i  = 5'd5;
        ram_data_i  = 32'hDEADBEEF;
        tick();
        ram_rw_en_i = 1'b0;
        n_checks++;
        if (ram_data_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL core_write_visible: got %h required deadbeef", ram_data_o);
        end
        ram_rw_en_i = 1'b1;
        ram_addr_i  = 5'd31;
        ram_data_i  = 32'h00000001;
        tick();
        ram_rw_en_i = 1'b0;
        ram_addr_i  = 5'd5;
        #1;
        n_checks++;
        if (ram_data_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL core_read_5: got %h required deadbeef", ram_data_o);
        end
        ram_addr_i = 5'd31;
        #1;
        n_checks++;
        if (ram_data_o !== 32'h00000001) begin
            n_fail++;
            $display("FAIL core_read_31: got %h required 00000001", ram_data_o);
        end
        ram_addr_i = 5'd6;
        #1;
        n_checks++;
        if (ram_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL core_read_6: got %h required 00000000", ram_data_o);
        end
    endtask

    task automatic test_full_load();
        logic [31:0] exp;
        // Byte offered in the cycle load_mode rises must not be taken.
        load_mode_i  = 1'b1;
        load_valid_i = 1'b1;
        load_byte_i  = 8'hAA;
        tick();
        load_valid_i = 1'b0;
        n_checks++;
        if (load_ready_o !== 1'b1 || load_sum_o !== 8'h00) begin
            n_fail++;
            $display("FAIL load_start: ready=%0b sum=%h required 1 00", load_ready_o, load_sum_o);
        end
        for (int k = 0; k < 128; k++)
            send_byte(8'(k));
        n_checks++;
        if (load_done_o !== 1'b1 || load_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: done=%0b ready=%0b required 1 0", load_done_o, load_ready_o);
        end
        n_checks++;
        if (load_sum_o !== 8'hC0) begin
            n_fail++;
            $display("FAIL load_sum: got %h required c0", load_sum_o);
        end
        for (int w = 0; w < 32; w++) begin
            exp = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
            ram_addr_i = 5'(w);
            #1;
            n_checks++;
            if (ram_data_o !== exp) begin
                n_fail++;
                $display("FAIL full_load_word[%0d]: got %h required %h", w, ram_data_o, exp);
            end
        end
        load_mode_i = 1'b0;
        tick();
    endtask

    task automatic test_stall_load();
        logic [31:0] exp;
        reset_i = 1'b1;
        tick();
        reset_i     = 1'b0;
        load_mode_i = 1'b1;
        ram_rw_en_i = 1'b1;
        ram_addr_i  = 5'd0;
        ram_data_i  = 32'hFFFFFFFF;
        tick();
        for (int k = 0; k < 128; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_byte(8'(k));
        end
        ram_rw_en_i = 1'b0;
        n_checks++;
        if (load_done_o !== 1'b1 || load_sum_o !== 8'hC0) begin
            n_fail++;
            $display("FAIL stall_done: done=%0b sum=%h required 1 c0", load_done_o, load_sum_o);
        end
        for (int w = 0; w < 32; w++) begin
            exp = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
            ram_addr_i = 5'(w);
            #1;
            n_checks++;
            if (ram_data_o !== exp) begin
                n_fail++;
                $display("FAIL stall_word[%0d]: got %h required %h", w, ram_data_o, exp);
            end
        end
        load_mode_i = 1'b0;
        tick();
    endtask

    // Expects the store to hold the full-load pattern on entry.
    task automatic test_abort();
        load_mode_i = 1'b1;
        tick();
        for (int k = 0; k < 10; k++)
            send_byte(8'h11);
        load_mode_i = 1'b0;
        tick();
        ram_addr_i = 5'd0;
        #1;
        n_checks++;
        if (ram_data_o !== 32'h11111111) begin
            n_fail++;
            $display("FAIL abort_word0: got %h required 11111111", ram_data_o);
        end
        ram_addr_i = 5'd1;
        #1;
        n_checks++;
        if (ram_data_o !== 32'h11111111) begin
            n_fail++;
            $display("FAIL abort_word1: got %h required 11111111", ram_data_o);
        end
        ram_addr_i = 5'd2;
        #1;
        n_checks++;
        if (ram_data_o !== 32'h0B0A0908) begin
            n_fail++;
            $display("FAIL abort_word2: got %h required 0b0a0908", ram_data_o);
        end
        n_checks++;
        if (load_ready_o !== 1'b0 || load_done_o !== 1'b0 || load_sum_o !== 8'hAA) begin
            n_fail++;
            $display("FAIL abort_idle: ready=%0b done=%0b sum=%h required 0 0 aa",
                     load_ready_o, load_done_o, load_sum_o);
        end
        load_mode_i = 1'b1;
        tick();
        n_checks++;
        if (load_ready_o !== 1'b1 || load_sum_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reentry: ready=%0b sum=%h required 1 00", load_ready_o, load_sum_o);
        end
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        ram_addr_i = 5'd0;
        #1;
        n_checks++;
        if (ram_data_o !== 32'h55443322 || load_sum_o !== 8'hEE) begin
            n_fail++;
            $display("FAIL reentry_word0: got %h sum %h required 55443322 ee", ram_data_o, load_sum_o);
        end
        load_mode_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_load();
        load_mode_i = 1'b1;
        tick();
        for (int k = 0; k <= 50; k++)
            send_byte(8'(k));
        reset_i = 1'b1;
        tick();
        reset_i     = 1'b0;
        load_mode_i = 1'b0;
        n_checks++;
        if ({load_ready_o, load_done_o, load_sum_o} !== 10'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: ready=%0b done=%0b sum=%h required 0 0 00",
                     load_ready_o, load_done_o, load_sum_o);
        end
        for (int a = 0; a < 32; a++) begin
            ram_addr_i = 5'(a);
            #1;
            n_checks++;
            if (ram_data_o !== 32'h0) begin
                n_fail++;
                $display("FAIL midreset_word[%0d]: got %h required 00000000", a, ram_data_o);
            end
        end
        tick();
        test_full_load();
    endtask

    initial begin
        reset_i      = 1'b1;
        ram_addr_i   = 5'd0;
        ram_rw_en_i  = 1'b0;
        ram_data_i   = 32'd0;
        load_mode_i  = 1'b0;
        load_valid_i = 1'b0;
        load_byte_i  = 8'd0;
        tick();
        tick();
        reset_i = 1'b0;
        test_reset();
        test_core_rw();
        test_full_load();
        test_abort();
        test_reset_mid_load();
        test_stall_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
